rgbgray_pixel_source: RTL
=========================

Name: rgbgray_pixel_source

Overview:
Producer end of the rgbgray image-stream conduit. Takes raw 12-bit RGB pixels and FVAL/LVAL framing from the CCD capture path and crops each frame to the configured window. It packs each pixel into a 32-bit word for the rgbgray consumer, driving data_valid, input_data, img_width, img_height and the consumer's stream reset. It sits in the pixel-clock domain, between CCD capture and the rgbgray input port of soc_system.

Parameters:
PIX_W, 12, input colour component width (must be >= 8)
RST_CYCLES, 4, cycles stream_reset_n is held low between frames (>= 1)
DIM_W, 16, width of the dimension and counter fields

Ports:
clk  in  1  pixel clock (ccd_pixel_clock domain); single clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  run enable; sampled only at frame boundaries
cfg_width  in  DIM_W  crop width in pixels (from camera width export)
cfg_height  in  DIM_W  crop height in lines (from camera height export)
fval  in  1  frame valid from capture
lval  in  1  line valid from capture
pix_valid  in  1  pixel strobe; pixel counts only when fval&lval&pix_valid
pix_r  in  PIX_W  red
pix_g  in  PIX_W  green
pix_b  in  PIX_W  blue
img_data_valid  out  1  output word valid (one-cycle strobe per pixel)
img_input_data  out  32  {8'h00, R[PIX_W-1 -: 8], G[..], B[..]}
img_width  out  DIM_W  width latched for the current frame
img_height  out  DIM_W  height latched for the current frame
stream_reset_n  out  1  active-low reset to the rgbgray consumer
frame_done  out  1  one-cycle pulse at end of each emitted frame
short_frame  out  1  sticky: a frame ended with fewer than img_height lines or a line with fewer than img_width pixels

Behaviour:
- Reset values: img_data_valid=0, img_input_data=0, img_width=0, img_height=0, stream_reset_n=0, frame_done=0, short_frame=0, state=IDLE, all counters=0.
- Async reset mid-frame aborts immediately. After release, the block waits for a fresh fval rising edge; no partial frame is ever emitted.
- States:
  - IDLE: stream_reset_n=0. Go to RST when enable=1, cfg_width!=0 and cfg_height!=0.
  - RST: stream_reset_n=0 for exactly RST_CYCLES cycles, then WAIT_SOF.
  - WAIT_SOF: stream_reset_n=1. If enable=0 or either cfg value is 0, go to IDLE. On fval 0->1 edge (registered previous fval=0, current=1): latch img_width<=cfg_width and img_height<=cfg_height, clear x/y, go to ACTIVE. If fval is already high on entry, wait for it to fall and rise again.
  - ACTIVE: process pixels. On fval 1->0, pulse frame_done, then go to RST (enable=1 and cfg nonzero) or IDLE.
- Pixel path:
  - Pixel accepted when fval&lval&pix_valid.
  - If x<img_width and y<img_height: output the word exactly 1 cycle later, with img_data_valid=1 for that cycle.
  - Otherwise drop silently. x increments on every accepted pixel and saturates at all-ones.
- Line boundary: on lval 1->0, if x>0 then y increments (saturating) and x clears. Lines with zero pixels do not count.
  - If a counted line has x<img_width and y<img_height (pre-increment), set short_frame.
- Frame end: on fval 1->0 with y<img_height, set short_frame.
  - If lval and fval fall in the same cycle, the line-end step runs before the frame-end check.
- cfg_width/cfg_height changes during ACTIVE are ignored until the next WAIT_SOF latch.
- img_width/img_height hold their latched value until the next latch; they are not cleared in RST or IDLE.
- enable=0 during ACTIVE takes effect only at frame end.
- short_frame clears only on reset_n.
- Packing: top 8 bits of each component, no rounding. Bits 31:24 = 0.
- Throughput: one pixel per clock sustained; no back-pressure.

Test Plan:
1. cfg 4x2, enable=1, RST_CYCLES=4. Drive a 4x2 frame of R=12'hFFF, G=12'h800, B=12'h00F on consecutive cycles -> stream_reset_n low 4 cycles after release, then 8 strobes of 32'h00FF8000, each 1 cycle after its input. img_width=4, img_height=2. One frame_done pulse, short_frame=0.
2. cfg 2x1, drive a 4x3 frame -> exactly 2 words (first 2 pixels of line 0) and no short_frame.
3. cfg 4x3, drive a 4x2 frame -> 8 words, frame_done pulses, short_frame=1 and stays 1 through the next good frame.
4. Release reset with fval already high -> no output until fval falls and rises. The next full frame is emitted normally.
5. Change cfg from 4x2 to 2x2 mid-frame -> current frame still emits 8 words with img_width=4. The next frame emits 4 words and shows img_width=2.
6. Assert reset_n low for 1 cycle mid-line -> all outputs return to reset values at once, no further words for that frame, and the next frame is emitted completely. Separately, deassert enable mid-frame -> the current frame completes, then IDLE with stream_reset_n=0.

Source files
------------

// File: rtl/rgbgray_pixel_source.sv
`default_nettype none
// ============================================================================
//  Module      : rgbgray_pixel_source
//  Description : Producer end of the rgbgray image-stream conduit. Crops the
//                incoming CCD pixel stream (fval/lval framing) to a window
//                latched at start of frame and packs each kept pixel into a
//                32-bit word {8'h00, R[7:0], G[7:0], B[7:0]} (top 8 bits of
//                each component). Also drives the consumer's stream reset
//                between frames and reports frames that are too short.
//  Ports       : clk, reset_n        - pixel clock, async active-low reset
//                enable              - run enable, sampled at frame boundaries
//                cfg_width/height    - requested crop window
//                fval, lval          - frame / line valid from capture
//                pix_valid, pix_r/g/b- pixel strobe and colour components
//                img_data_valid      - one-cycle strobe per emitted word
//                img_input_data      - packed pixel word
//                img_width/height    - window latched for the current frame
//                stream_reset_n      - active-low reset to the consumer
//                frame_done          - pulse at end of each emitted frame
//                short_frame         - sticky short line / short frame flag
//  Revision    : 1.0 - initial release
// ============================================================================
module rgbgray_pixel_source #(
    parameter int PIX_W      = 12,
    parameter int RST_CYCLES = 4,
    parameter int DIM_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic             fval,
    input  logic             lval,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_r,
    input  logic [PIX_W-1:0] pix_g,
    input  logic [PIX_W-1:0] pix_b,
    output logic             img_data_valid,
    output logic [31:0]      img_input_data,
    output logic [DIM_W-1:0] img_width,
    output logic [DIM_W-1:0] img_height,
    output logic             stream_reset_n,
    output logic             frame_done,
    output logic             short_frame
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RST      = 2'd1,
        S_WAIT_SOF = 2'd2,
        S_ACTIVE   = 2'd3
    } state_t;

    localparam int c_RST_CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_RST_CNT_W-1:0] c_RST_LAST = c_RST_CNT_W'(RST_CYCLES - 1);

    state_t                 r_state;
    logic [c_RST_CNT_W-1:0] r_rst_cnt;
    logic [DIM_W-1:0]       r_x;
    logic [DIM_W-1:0]       r_y;
    logic                   r_fval_d;
    logic                   r_lval_d;

    logic                   w_cfg_ok;
    logic                   w_pix_acc;
    logic                   w_fval_rise;
    logic                   w_fval_fall;
    logic                   w_lval_fall;
    logic                   w_in_window;
    logic                   w_line_counted;
    logic                   w_line_short;
    logic                   w_frame_short;
    logic [DIM_W-1:0]       w_x_inc;
    logic [DIM_W-1:0]       w_y_inc;
    logic [DIM_W-1:0]       w_y_after;
    logic [31:0]            w_word;

    // Only the top 8 bits of each component are packed.
    if (PIX_W > 8) begin : g_unused_lsbs
        logic w_unused_lsbs;
        assign w_unused_lsbs = ^{pix_r[PIX_W-9:0], pix_g[PIX_W-9:0], pix_b[PIX_W-9:0]};
    end

    assign w_cfg_ok    = enable && (cfg_width != '0) && (cfg_height != '0);
    assign w_pix_acc   = fval & lval & pix_valid;
    assign w_fval_rise = fval & ~r_fval_d;
    assign w_fval_fall = ~fval & r_fval_d;
    assign w_lval_fall = ~lval & r_lval_d;

    // Saturating position counters so oversized frames cannot wrap back into
    // the crop window.
    assign w_x_inc = (&r_x) ? r_x : r_x + DIM_W'(1);
    assign w_y_inc = (&r_y) ? r_y : r_y + DIM_W'(1);

    assign w_in_window    = (r_x < img_width) && (r_y < img_height);
    assign w_line_counted = w_lval_fall && (r_x != '0);
    assign w_line_short   = w_line_counted && w_in_window;

    // Frame-end check sees the line count after a coincident line end.
    assign w_y_after     = w_line_counted ? w_y_inc : r_y;
    assign w_frame_short = (w_y_after < img_height);

    assign w_word = {8'h00, pix_r[PIX_W-1 -: 8], pix_g[PIX_W-1 -: 8], pix_b[PIX_W-1 -: 8]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_rst_cnt      <= '0;
            r_x            <= '0;
            r_y            <= '0;
            r_fval_d       <= 1'b0;
            r_lval_d       <= 1'b0;
            img_data_valid <= 1'b0;
            img_input_data <= '0;
            img_width      <= '0;
            img_height     <= '0;
            stream_reset_n <= 1'b0;
            frame_done     <= 1'b0;
            short_frame    <= 1'b0;
        end else begin
            r_fval_d       <= fval;
            r_lval_d       <= lval;
            img_data_valid <= 1'b0;
            frame_done     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    stream_reset_n <= 1'b0;
                    if (w_cfg_ok) begin
                        r_state   <= S_RST;
                        r_rst_cnt <= '0;
                    end
                end

                S_RST: begin
                    if (r_rst_cnt == c_RST_LAST) begin
                        r_state        <= S_WAIT_SOF;
                        r_rst_cnt      <= '0;
                        stream_reset_n <= 1'b1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + c_RST_CNT_W'(1);
                    end
                end

                S_WAIT_SOF: begin
                    if (!w_cfg_ok) begin
                        r_state        <= S_IDLE;
                        stream_reset_n <= 1'b0;
                    end else if (w_fval_rise) begin
                        // An fval already high on entry never looks like a
                        // rising edge here, so a partial frame is skipped.
                        r_state    <= S_ACTIVE;
                        img_width  <= cfg_width;
                        img_height <= cfg_height;
                        r_x        <= '0;
                        r_y        <= '0;
                        // A pixel arriving with the rising edge is pixel (0,0),
                        // which is always inside a nonzero window.
                        if (w_pix_acc) begin
                            r_x            <= DIM_W'(1);
                            img_data_valid <= 1'b1;
                            img_input_data <= w_word;
                        end
                    end
                end

                S_ACTIVE: begin
                    if (w_pix_acc) begin
                        r_x <= w_x_inc;
                        if (w_in_window) begin
                            img_data_valid <= 1'b1;
                            img_input_data <= w_word;
                        end
                    end
                    if (w_line_counted) begin
                        r_x <= '0;
                        r_y <= w_y_inc;
                        if (w_line_short) begin
                            short_frame <= 1'b1;
                        end
                    end
                    if (w_fval_fall) begin
                        frame_done     <= 1'b1;
                        stream_reset_n <= 1'b0;
                        r_rst_cnt      <= '0;
                        r_state        <= w_cfg_ok ? S_RST : S_IDLE;
                        if (w_frame_short) begin
                            short_frame <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state        <= S_IDLE;
                    stream_reset_n <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
